vga_timing_gen: RTL

Parametrised successor to the fixed 640x480 display-signal generator. Produces pixel/line counters, sync pulses with selectable polarity, an active-video flag, and line/frame boundary pulses for any VESA-style mode. Sits between the pixel-strobe divider and the character/pixel renderer. All outputs are registered and mutually coherent, with no off-by-one in the active window.

---
 rtl/vga_timing_pkg.sv | 60 ++++++
 rtl/vga_axis_counter.sv | 57 +++++
 rtl/vga_timing_gen.sv | 81 ++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// Shared constants and helpers for the VGA timing generator.
// Holds the standard 640x480@60 and 800x600@60 mode numbers and the
// arithmetic that turns active/porch/sync widths into totals and windows.
package vga_timing_pkg;

  // 640x480 @ 60 Hz (25.175 MHz pixel clock)
  localparam int VGA640_H_ACTIVE = 640;
  localparam int VGA640_H_FP     = 16;
  localparam int VGA640_H_SYNC   = 96;
  localparam int VGA640_H_BP     = 48;
  localparam int VGA640_V_ACTIVE = 480;
  localparam int VGA640_V_FP     = 10;
  localparam int VGA640_V_SYNC   = 2;
  localparam int VGA640_V_BP     = 33;
  localparam bit VGA640_HS_POL   = 1'b0;
  localparam bit VGA640_VS_POL   = 1'b0;

  // 800x600 @ 60 Hz (40 MHz pixel clock)
  localparam int VGA800_H_ACTIVE = 800;
  localparam int VGA800_H_FP     = 40;
  localparam int VGA800_H_SYNC   = 128;
  localparam int VGA800_H_BP     = 88;
  localparam int VGA800_V_ACTIVE = 600;
  localparam int VGA800_V_FP     = 1;
  localparam int VGA800_V_SYNC   = 4;
  localparam int VGA800_V_BP     = 23;
  localparam bit VGA800_HS_POL   = 1'b1;
  localparam bit VGA800_VS_POL   = 1'b1;

  // Total positions on one axis (line length or frame height).
  function automatic int axis_total(input int active, input int fp,
                                    input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  // First position inside the sync pulse.
  function automatic int sync_start(input int active, input int fp);
    return active + fp;
  endfunction

  // First position after the sync pulse (exclusive end).
  function automatic int sync_end(input int active, input int fp, input int sync);
    return active + fp + sync;
  endfunction

  localparam int VGA640_H_TOTAL      = axis_total(VGA640_H_ACTIVE, VGA640_H_FP, VGA640_H_SYNC, VGA640_H_BP);
  localparam int VGA640_V_TOTAL      = axis_total(VGA640_V_ACTIVE, VGA640_V_FP, VGA640_V_SYNC, VGA640_V_BP);
  localparam int VGA640_H_SYNC_START = sync_start(VGA640_H_ACTIVE, VGA640_H_FP);
  localparam int VGA640_H_SYNC_END   = sync_end(VGA640_H_ACTIVE, VGA640_H_FP, VGA640_H_SYNC);
  localparam int VGA640_V_SYNC_START = sync_start(VGA640_V_ACTIVE, VGA640_V_FP);
  localparam int VGA640_V_SYNC_END   = sync_end(VGA640_V_ACTIVE, VGA640_V_FP, VGA640_V_SYNC);

  localparam int VGA800_H_TOTAL      = axis_total(VGA800_H_ACTIVE, VGA800_H_FP, VGA800_H_SYNC, VGA800_H_BP);
  localparam int VGA800_V_TOTAL      = axis_total(VGA800_V_ACTIVE, VGA800_V_FP, VGA800_V_SYNC, VGA800_V_BP);
  localparam int VGA800_H_SYNC_START = sync_start(VGA800_H_ACTIVE, VGA800_H_FP);
  localparam int VGA800_H_SYNC_END   = sync_end(VGA800_H_ACTIVE, VGA800_H_FP, VGA800_H_SYNC);
  localparam int VGA800_V_SYNC_START = sync_start(VGA800_V_ACTIVE, VGA800_V_FP);
  localparam int VGA800_V_SYNC_END   = sync_end(VGA800_V_ACTIVE, VGA800_V_FP, VGA800_V_SYNC);

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis (horizontal or vertical): a wrapping position counter
// plus decode of the active and sync windows on the *next* position, so the
// parent can register those flags on the same edge the counter moves.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int SYNC   = 96,
  parameter int BP     = 48,
  parameter int CW     = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  output logic [CW-1:0] count,
  output logic          wrap,
  output logic          active_nxt,
  output logic          sync_nxt
);

  localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);

  // Window bounds are held one bit wider than the counter so an exclusive
  // end equal to 2^CW still compares correctly.
  localparam logic [CW-1:0] LAST    = CW'(TOTAL - 1);
  localparam logic [CW:0]   ACT_END = (CW+1)'(ACTIVE);
  localparam logic [CW:0]   SYNC_LO = (CW+1)'(sync_start(ACTIVE, FP));
  localparam logic [CW:0]   SYNC_HI = (CW+1)'(sync_end(ACTIVE, FP, SYNC));

  logic [CW-1:0] count_nxt;
  logic [CW:0]   count_ext;

  // Next position and window decode of that next position.
  always_comb begin
    wrap      = en && (count == LAST);
    count_nxt = count;
    if (wrap) begin
      count_nxt = '0;
    end else if (en) begin
      count_nxt = count + 1'b1;
    end
    count_ext  = {1'b0, count_nxt};
    active_nxt = (count_ext < ACT_END);
    sync_nxt   = (count_ext >= SYNC_LO) && (count_ext < SYNC_HI);
  end

  // Position register; reset returns the axis to position 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else begin
      count <= count_nxt;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA/VESA display timing generator. The horizontal axis advances on each
// pixel strobe; its wrap advances the vertical axis. Every output is a flop
// loaded from the next-state decode, so sync, valid and the boundary pulses
// change on exactly the same edge as xPos/yPos.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = VGA640_H_ACTIVE,
  parameter int H_FP     = VGA640_H_FP,
  parameter int H_SYNC   = VGA640_H_SYNC,
  parameter int H_BP     = VGA640_H_BP,
  parameter int V_ACTIVE = VGA640_V_ACTIVE,
  parameter int V_FP     = VGA640_V_FP,
  parameter int V_SYNC   = VGA640_V_SYNC,
  parameter int V_BP     = VGA640_V_BP,
  parameter bit HS_POL   = VGA640_HS_POL,
  parameter bit VS_POL   = VGA640_VS_POL,
  parameter int CW       = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          strobe,
  output logic [CW-1:0] xPos,
  output logic [CW-1:0] yPos,
  output logic          horizSync,
  output logic          vertSync,
  output logic          valid,
  output logic          line_start,
  output logic          frame_start
);

  logic h_wrap, h_active_nxt, h_sync_nxt;
  logic v_wrap, v_active_nxt, v_sync_nxt;

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .CW(CW)
  ) u_h (
    .clk       (clk),
    .reset     (reset),
    .en        (strobe),
    .count     (xPos),
    .wrap      (h_wrap),
    .active_nxt(h_active_nxt),
    .sync_nxt  (h_sync_nxt)
  );

  // The line counter only moves when the pixel counter wraps.
  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .CW(CW)
  ) u_v (
    .clk       (clk),
    .reset     (reset),
    .en        (h_wrap),
    .count     (yPos),
    .wrap      (v_wrap),
    .active_nxt(v_active_nxt),
    .sync_nxt  (v_sync_nxt)
  );

  // Register decoded outputs on strobe; boundary pulses last one clk only.
  // Reset itself never raises line_start/frame_start.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid       <= 1'b1;
      horizSync   <= ~HS_POL;
      vertSync    <= ~VS_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (strobe) begin
      valid       <= h_active_nxt && v_active_nxt;
      horizSync   <= h_sync_nxt ? HS_POL : ~HS_POL;
      vertSync    <= v_sync_nxt ? VS_POL : ~VS_POL;
      line_start  <= h_wrap;
      frame_start <= v_wrap;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

endmodule
